// File: rtl/inst_fetch_seq.sv
`default_nettype none
// ============================================================================
//  Module   : inst_fetch_seq
//  Purpose  : Instruction fetch and sequencing for the 4-bit accumulator CPU.
//             Owns the PC, fetches instruction words from program ROM over a
//             req/ack handshake, presents registered opcode/immediate fields
//             to the decoder, registers the ALU carry and applies the
//             decoder's active-low PC-load strobe at the end of EXEC.
//  Revision : 1.0 - initial release
// ============================================================================
module inst_fetch_seq #(
  parameter int ADDR_W = 4,
  parameter int IMM_W  = 4
) (
  input  logic                 clkin,
  input  logic                 rstin,
  input  logic                 haltin,
  input  logic                 stepin,
  output logic [ADDR_W-1:0]    rom_addrout,
  output logic                 rom_reqout,
  input  logic                 rom_ackin,
  input  logic [IMM_W+3:0]     rom_datain,
  output logic                 op0out,
  output logic                 op1out,
  output logic                 op2out,
  output logic                 op3out,
  output logic [IMM_W-1:0]     immout,
  output logic                 cout,
  input  logic                 alu_cin,
  input  logic                 ld3in,
  input  logic [ADDR_W-1:0]    pc_datain,
  output logic                 execout,
  output logic                 haltedout
);

  typedef enum logic [1:0] {
    ST_RESET_WAIT = 2'd0,
    ST_FETCH      = 2'd1,
    ST_EXEC       = 2'd2,
    ST_HALT       = 2'd3
  } state_t;

  state_t              r_state;
  logic [ADDR_W-1:0]   r_pc;
  logic                r_req;
  logic                r_exec;
  logic                r_halted;
  logic                r_step;     // set while a single-step instruction is in flight
  logic [3:0]          r_op;
  logic [IMM_W-1:0]    r_imm;
  logic                r_carry;
  logic [ADDR_W-1:0]   w_pc_inc;

  // Sequential PC increment; natural overflow gives the 15 -> 0 wrap.
  assign w_pc_inc = r_pc + ADDR_W'(1);

  // Sequencer FSM: all outputs are registered and cleared asynchronously,
  // so an in-flight request drops as soon as reset is asserted.
  always_ff @(posedge clkin or posedge rstin) begin
    if (rstin) begin
      r_state  <= ST_RESET_WAIT;
      r_pc     <= '0;
      r_req    <= 1'b0;
      r_exec   <= 1'b0;
      r_halted <= 1'b0;
      r_step   <= 1'b0;
      r_op     <= '0;
      r_imm    <= '0;
      r_carry  <= 1'b0;
    end else begin
      case (r_state)
        ST_RESET_WAIT: begin
          if (haltin) begin
            r_state  <= ST_HALT;
            r_halted <= 1'b1;
          end else begin
            r_state  <= ST_FETCH;
            r_req    <= 1'b1;
          end
        end

        ST_FETCH: begin
          // Request and address stay stable until the ROM acknowledges.
          if (rom_ackin) begin
            r_op    <= rom_datain[IMM_W+3:IMM_W];
            r_imm   <= rom_datain[IMM_W-1:0];
            r_req   <= 1'b0;
            r_exec  <= 1'b1;
            r_state <= ST_EXEC;
          end
        end

        ST_EXEC: begin
          r_exec  <= 1'b0;
          // Carry seen by the decoder is always that of the previous instruction.
          r_carry <= alu_cin;
          // Active-low load: a jump takes the target verbatim, even at PC=max.
          if (!ld3in) begin
            r_pc <= pc_datain;
          end else begin
            r_pc <= w_pc_inc;
          end
          r_step <= 1'b0;
          if (haltin || r_step) begin
            r_state  <= ST_HALT;
            r_halted <= 1'b1;
          end else begin
            r_state  <= ST_FETCH;
            r_req    <= 1'b1;
          end
        end

        ST_HALT: begin
          // Step has priority over resume; otherwise hold everything.
          if (stepin) begin
            r_state  <= ST_FETCH;
            r_req    <= 1'b1;
            r_halted <= 1'b0;
            r_step   <= 1'b1;
          end else if (!haltin) begin
            r_state  <= ST_FETCH;
            r_req    <= 1'b1;
            r_halted <= 1'b0;
            r_step   <= 1'b0;
          end
        end

        default: begin
          r_state  <= ST_RESET_WAIT;
          r_req    <= 1'b0;
          r_exec   <= 1'b0;
          r_halted <= 1'b0;
          r_step   <= 1'b0;
        end
      endcase
    end
  end

  assign rom_addrout = r_pc;
  assign rom_reqout  = r_req;
  assign op0out      = r_op[0];
  assign op1out      = r_op[1];
  assign op2out      = r_op[2];
  assign op3out      = r_op[3];
  assign immout      = r_imm;
  assign cout        = r_carry;
  assign execout     = r_exec;
  assign haltedout   = r_halted;

endmodule
`default_nettype wire

// File: tb/tb_inst_fetch_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_inst_fetch_seq
//  Purpose  : Directed self-checking bench for inst_fetch_seq.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_inst_fetch_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       haltin, stepin;
  logic [3:0] rom_addr;
  logic       rom_req, rom_ack;
  logic [7:0] rom_data;
  logic       op0, op1, op2, op3;
  logic [3:0] imm;
  logic       carry;
  logic       alu_cin, ld3in;
  logic [3:0] pc_data;
  logic       execo, haltedo;

  int n_tests = 0;
  int n_fail  = 0;

  inst_fetch_seq #(.ADDR_W(4), .IMM_W(4)) dut (
    .clkin      (clk),
    .rstin      (rst),
    .haltin     (haltin),
    .stepin     (stepin),
    .rom_addrout(rom_addr),
    .rom_reqout (rom_req),
    .rom_ackin  (rom_ack),
    .rom_datain (rom_data),
    .op0out     (op0),
    .op1out     (op1),
    .op2out     (op2),
    .op3out     (op3),
    .immout     (imm),
    .cout       (carry),
    .alu_cin    (alu_cin),
    .ld3in      (ld3in),
    .pc_datain  (pc_data),
    .execout    (execo),
    .haltedout  (haltedo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(negedge clk);
  endtask

  // Entered at a negedge with the DUT in FETCH; leaves at the negedge after EXEC.
  task automatic run_inst(input logic [7:0] word, input int wait_cyc,
                          input logic [3:0] exp_pc, input logic exp_cout,
                          input logic cin, input logic ld, input logic [3:0] tgt);
    for (int i = 0; i <= wait_cyc; i++) begin
      check("fetch_req", rom_req, 1'b1);
      check("fetch_addr", rom_addr, exp_pc);
      check("fetch_noexec", execo, 1'b0);
      check("fetch_nohalt", haltedo, 1'b0);
      if (i == wait_cyc) begin
        rom_ack  = 1'b1;
        rom_data = word;
      end else begin
        rom_ack  = 1'b0;
        rom_data = 8'hFF;
      end
      tick();
    end
    rom_ack  = 1'b0;
    rom_data = 8'hFF;
    check("exec_pulse", execo, 1'b1);
    check("exec_req", rom_req, 1'b0);
    check("exec_op", {op3, op2, op1, op0}, word[7:4]);
    check("exec_imm", imm, word[3:0]);
    check("exec_cout", carry, exp_cout);
    check("exec_addr", rom_addr, exp_pc);
    alu_cin = cin;
    ld3in   = ld;
    pc_data = tgt;
    tick();
    alu_cin = 1'b0;
    ld3in   = 1'b1;
    pc_data = 4'h0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; haltin = 1'b0; stepin = 1'b0; rom_ack = 1'b0; rom_data = 8'h00;
    alu_cin = 1'b0; ld3in = 1'b1; pc_data = 4'h0;
    tick(); tick();
    check("rst_req", rom_req, 1'b0);
    check("rst_addr", rom_addr, 4'h0);
    check("rst_exec", execo, 1'b0);
    check("rst_halted", haltedo, 1'b0);
    check("rst_cout", carry, 1'b0);
    check("rst_op", {op3, op2, op1, op0}, 4'h0);
    check("rst_imm", imm, 4'h0);
    rst = 1'b0;
    tick();

    // Single-cycle acks: words 0x31, 0x52; second one produces a carry.
    run_inst(8'h31, 0, 4'h0, 1'b0, 1'b0, 1'b1, 4'h0);
    run_inst(8'h52, 0, 4'h1, 1'b0, 1'b1, 1'b1, 4'h0);
    // Delayed ack (req held 4 cycles); carry from previous is visible here.
    run_inst(8'h7E, 3, 4'h2, 1'b1, 1'b0, 1'b1, 4'h0);
    // Jump to 0xA; stray step pulse outside HALT must be ignored.
    stepin = 1'b1;
    run_inst(8'h90, 0, 4'h3, 1'b0, 1'b0, 1'b0, 4'hA);
    stepin = 1'b0;
    run_inst(8'h11, 1, 4'hA, 1'b0, 1'b0, 1'b0, 4'hF);
    // Increment wraps F -> 0.
    run_inst(8'h22, 0, 4'hF, 1'b0, 1'b1, 1'b1, 4'h0);
    run_inst(8'h33, 0, 4'h0, 1'b1, 1'b0, 1'b0, 4'hF);
    // Jump at PC=F takes the target verbatim.
    run_inst(8'h44, 0, 4'hF, 1'b0, 1'b0, 1'b0, 4'h5);

    // Halt requested mid-fetch: the instruction still completes.
    haltin = 1'b1;
    run_inst(8'h55, 2, 4'h5, 1'b0, 1'b1, 1'b1, 4'h0);
    check("halt_flag", haltedo, 1'b1);
    check("halt_req", rom_req, 1'b0);
    check("halt_addr", rom_addr, 4'h6);
    check("halt_cout", carry, 1'b1);
    tick();
    check("halt_hold_flag", haltedo, 1'b1);
    check("halt_hold_exec", execo, 1'b0);
    check("halt_hold_req", rom_req, 1'b0);

    // One step pulse runs exactly one instruction.
    stepin = 1'b1;
    tick();
    stepin = 1'b0;
    run_inst(8'h66, 0, 4'h6, 1'b1, 1'b0, 1'b1, 4'h0);
    check("step_rehalt", haltedo, 1'b1);
    check("step_addr", rom_addr, 4'h7);
    tick();
    check("step_noexec", execo, 1'b0);
    check("step_noreq", rom_req, 1'b0);
    check("step_still_halted", haltedo, 1'b1);

    // Resume free-run.
    haltin = 1'b0;
    tick();
    run_inst(8'h77, 0, 4'h7, 1'b0, 1'b1, 1'b0, 4'h5);
    check("pre_rst_req", rom_req, 1'b1);
    check("pre_rst_addr", rom_addr, 4'h5);
    check("pre_rst_cout", carry, 1'b1);

    // Reset mid-fetch clears everything without waiting for a clock edge.
    #2 rst = 1'b1;
    #1;
    check("arst_req", rom_req, 1'b0);
    check("arst_addr", rom_addr, 4'h0);
    check("arst_cout", carry, 1'b0);
    check("arst_exec", execo, 1'b0);
    tick();
    check("arst_hold_exec", execo, 1'b0);
    check("arst_hold_req", rom_req, 1'b0);
    rst = 1'b0;
    tick();
    check("post_rst_req", rom_req, 1'b1);
    check("post_rst_addr", rom_addr, 4'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/inst_fetch_seq.md
Name: inst_fetch_seq

Overview:
- Instruction fetch and sequencing unit for the 4-bit accumulator CPU.
- Owns the program counter and fetches 8-bit instruction words from program ROM over a req/ack handshake.
- Splits each word into the opcode bits that feed the opcode decoder and a 4-bit immediate.
- Registers the ALU carry, producing the carry input the decoder uses for conditional jumps.
- Applies the decoder's active-low PC-load strobe on the execute cycle.

Parameters:
- ADDR_W, 4, program counter / ROM address width.
- IMM_W, 4, immediate field width; instruction word width is 4+IMM_W.

Ports:
- clkin  input  1  system clock, rising edge.
- rstin  input  1  asynchronous, active-high reset.
- haltin  input  1  level; when 1, stop at the next instruction boundary.
- stepin  input  1  one-cycle pulse; while halted, runs exactly one instruction.
- rom_addrout  output  ADDR_W  ROM address, equal to the PC.
- rom_reqout  output  1  fetch request.
- rom_ackin  input  1  ROM ack; rom_datain is valid in the same cycle.
- rom_datain  input  4+IMM_W  instruction word: [7:4] opcode (bit 4 = op0), [3:0] immediate.
- op0out, op1out, op2out, op3out  output  1 each  registered opcode bits to the decoder.
- immout  output  IMM_W  registered immediate.
- cout  output  1  registered carry flag to the decoder cin.
- alu_cin  input  1  ALU carry-out for the current instruction.
- ld3in  input  1  decoder PC-load strobe, active low.
- pc_datain  input  ADDR_W  ALU result, used as the jump target.
- execout  output  1  one-cycle pulse; register-file load enables are honoured only in this cycle.
- haltedout  output  1  high while in HALT.

Behaviour:
- States: RESET_WAIT, FETCH, EXEC, HALT. Encoding is free.
- Reset (async assert; release sampled on clkin):
  - state=RESET_WAIT, PC=0, op*out=0, immout=0, cout=0.
  - rom_reqout=0, execout=0, haltedout=0.
- RESET_WAIT: one cycle after reset release, go to FETCH (or HALT if haltin=1).
- FETCH:
  - rom_reqout=1 and rom_addrout=PC, both held stable until ack.
  - On rom_ackin=1: register rom_datain[7:4] into op3..op0out and [3:0] into immout, then go to EXEC.
  - Minimum fetch latency is one cycle (ack in the first req cycle). No timeout.
  - rom_ackin while rom_reqout=0 is ignored.
- EXEC (exactly one cycle, execout=1):
  - Decoder and ALU are combinational on the registered op/imm.
  - At the clock edge ending EXEC:
    - cout <= alu_cin on every instruction.
    - If ld3in=0, PC <= pc_datain; else PC <= PC+1, wrapping modulo 2^ADDR_W (15 -> 0).
  - Next state: HALT if haltin=1 or a step was in progress; otherwise FETCH.
- HALT:
  - haltedout=1, rom_reqout=0; PC, op, imm and cout hold.
  - stepin=1 -> FETCH with the step flag set (exactly one instruction, then back to HALT).
  - haltin=0 and stepin=0 -> FETCH (resume free-run).
- Timing of haltin: asserting haltin during FETCH does not abort the fetch; the in-flight instruction completes. Halt takes effect only after EXEC.
- stepin outside HALT is ignored.
- Simultaneous jump and wrap: a jump wins; pc_datain is taken verbatim.
- Carry: cout is updated only at the end of EXEC. The decoder therefore sees the carry produced by the previous instruction, as required for JNC.
- Reset mid-fetch or mid-exec: immediately abort; rom_reqout drops asynchronously; no PC or carry update.

Test Plan:
1. Reset release, ROM acks each request in its first cycle with words 0x31,0x52 at addr 0,1 -> op bits 0011 with imm 1, then op bits 0101 with imm 2, PC 0->1->2, execout pulses every 2nd cycle.
2. ROM ack delayed 3 cycles -> rom_reqout held 4 cycles with rom_addrout stable at PC; execout single pulse after ack.
3. EXEC with ld3in=0, pc_datain=0xA -> next rom_addrout=0xA; with ld3in=1 at PC=0xF -> next rom_addrout=0x0.
4. alu_cin=1 in EXEC of instruction N -> cout=1 during instruction N+1's EXEC; alu_cin=0 there -> cout=0 for N+2.
5. haltin raised mid-FETCH -> that instruction executes, then haltedout=1, rom_reqout=0. One stepin pulse -> exactly one execout, then HALT again. haltin drop -> free-run resumes.
6. rstin asserted while rom_reqout=1 at PC=5 -> rom_reqout=0 within the same cycle, PC=0, cout=0, no execout.
